// File: rtl/uart_pkg.sv
// Constants, FSM encoding and frame helper shared by the UART TX and RX paths.
package uart_pkg;

  localparam int DEFAULT_CLK_DIV    = 104;  // 12 MHz / 115200 baud
  localparam int DEFAULT_GUARD_BITS = 15;
  localparam int DATA_BITS          = 8;
  localparam int FRAME_BITS         = 10;   // start + 8 data + stop

  typedef enum logic [1:0] {
    GUARD,
    IDLE,
    SHIFT
  } tx_state_t;

  // 8N1 frame, bit 0 goes on the wire first.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_BITS-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO, pointer-extended full/empty; push/pop take effect on the next edge.
// Push while full and pop while empty are ignored; flags depend on registered pointers only.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = DATA_BITS,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic                do_push;
  logic                do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
                    (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);
  assign level    = wptr - rptr;
  assign pop_data = mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 transmitter: FIFO-fed serializer, tx registered (start bit 2 cycles after wr in IDLE).
// Writes while full are dropped and latch the sticky overflow flag; no combinational path from wr.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DEPTH_LOG2 = 3,
  parameter int GUARD_BITS = DEFAULT_GUARD_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_BITS-1:0]  tx_data,
  output logic                  tx,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  overflow
);

  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int BIT_W     = $clog2(FRAME_BITS);
  localparam int GUARD_CYC = GUARD_BITS * CLK_DIV;
  localparam int GUARD_W   = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);

  tx_state_t              state;
  tx_state_t              state_n;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       div_n;
  logic [BIT_W-1:0]       bit_q;
  logic [BIT_W-1:0]       bit_n;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  shreg_n;
  logic [GUARD_W-1:0]     guard_q;
  logic [GUARD_W-1:0]     guard_n;
  logic                   pop;
  logic [DATA_BITS-1:0]   fifo_data;

  uart_byte_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_comb begin
    state_n = state;
    div_n   = div_q;
    bit_n   = bit_q;
    shreg_n = shreg;
    guard_n = guard_q;
    pop     = 1'b0;
    case (state)
      GUARD: begin
        if (guard_q == GUARD_LAST) state_n = IDLE;
        else                       guard_n = guard_q + 1'b1;
      end
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = frame_of(fifo_data);
          div_n   = '0;
          bit_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_n = '0;
          if (bit_q == BIT_LAST) begin
            // Stop bit done: chain straight into the next queued byte.
            if (!empty) begin
              pop     = 1'b1;
              shreg_n = frame_of(fifo_data);
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            shreg_n = {1'b1, shreg[FRAME_BITS-1:1]};
            bit_n   = bit_q + 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      default: state_n = GUARD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= GUARD;
      div_q    <= '0;
      bit_q    <= '0;
      shreg    <= '1;
      guard_q  <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      div_q    <= div_n;
      bit_q    <= bit_n;
      shreg    <= shreg_n;
      guard_q  <= guard_n;
      tx       <= (state == SHIFT) ? shreg[0] : 1'b1;
      overflow <= overflow | (wr & full);
    end
  end

  assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Random and directed stimulus against a queue-based transmitter model; a line monitor checks every tx cycle.
module tb_uart_tx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int GUARD_BITS = 2;
  localparam int DEPTH      = 8;
  localparam int G          = GUARD_BITS * CLK_DIV;
  localparam int FRAME_CYC  = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       busy;
  logic       overflow;

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .DEPTH_LOG2 (3),
    .GUARD_BITS (GUARD_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .tx_data  (tx_data),
    .tx       (tx),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;        // rising edges since reset release
  logic [7:0] mq[$];          // bytes queued, not yet handed to the shifter
  exp_t       exp_q[$];       // frames expected on the line, with start cycle
  int         frame_end = 0;  // edge at which the current frame's stop bit completes
  bit         ovf_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Spec-level model of one rising edge: full is judged before the pop, the
  // shifter takes a byte once guard is over and the previous frame is done.
  task automatic model_step(input bit w, input logic [7:0] d);
    bit         accept;
    logic [7:0] b;
    exp_t       e;
    accept = w && (mq.size() < DEPTH);
    if (w && !accept) ovf_m = 1'b1;
    if (mq.size() > 0 && cyc >= G + 1 && cyc >= frame_end) begin
      b = mq.pop_front();
      e.b = b;
      e.start = cyc + 1;
      exp_q.push_back(e);
      frame_end = cyc + FRAME_CYC;
    end
    if (accept) mq.push_back(d);
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    check("level", 32'(level), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("empty", 32'(empty), 32'(n == 0));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("busy", 32'(busy), 32'(cyc < G || cyc < frame_end || n > 0));
  endtask

  task automatic tick(input bit w, input logic [7:0] d);
    wr = w;
    tx_data = d;
    @(posedge clk);
    cyc++;
    model_step(w, d);
    @(negedge clk);
    wr = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_level", 32'(level), 32'(0));
    check("rst_full", 32'(full), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_busy", 32'(busy), 32'(1));
    mq.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    frame_end = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    check_outputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mq.size() > 0 || cyc < frame_end + 3) && n < budget) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'(1));
  endtask

  // Line monitor: every cycle tx must be idle-high or the expected frame bit.
  initial begin
    bit         in_frame;
    int         fcnt;
    logic [9:0] fbits;
    exp_t       e;
    in_frame = 1'b0;
    fcnt = 0;
    fbits = '1;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && exp_q.size() > 0 && exp_q[0].start == cyc) begin
          e = exp_q.pop_front();
          fbits = {1'b1, e.b, 1'b0};
          fcnt = 0;
          in_frame = 1'b1;
        end
        if (in_frame) begin
          check("tx_bit", 32'(tx), 32'(fbits[fcnt / CLK_DIV]));
          fcnt++;
          if (fcnt == FRAME_CYC) in_frame = 1'b0;
        end else begin
          check("tx_idle", 32'(tx), 32'(1));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    do_reset();
    // Guard period then IDLE with no frame.
    repeat (12) tick(1'b0, 8'h00);

    // Single byte from IDLE.
    tick(1'b1, 8'h55);
    drain(200);

    // Three bytes queued behind an active frame: level 1,2,3, then contiguous.
    tick(1'b1, 8'h11);
    repeat (5) tick(1'b0, 8'h00);
    tick(1'b1, 8'hA5);
    tick(1'b1, 8'h3C);
    tick(1'b1, 8'hFF);
    drain(400);

    // Nine writes during guard; the ninth lands on the first pop while full.
    do_reset();
    for (int i = 0; i < 9; i++) tick(1'b1, 8'(8'h20 + i));
    drain(600);

    // Reset in the middle of bit 4 of 0x81; overflow from above must clear.
    repeat (3) tick(1'b0, 8'h00);
    tick(1'b1, 8'h81);
    repeat (19) tick(1'b0, 8'h00);
    do_reset();
    repeat (60) tick(1'b0, 8'h00);

    // Random traffic with light, medium and overflowing write rates.
    for (int blk = 0; blk < 15; blk++) begin
      case (blk % 3)
        0:       p = 5;
        1:       p = 20;
        default: p = 60;
      endcase
      repeat (200) tick(bit'($urandom_range(0, 99) < p), 8'($urandom));
    end
    drain(1000);

    check("all_frames_sent", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: an 8-deep byte FIFO feeding an 8N1 serializer, the transmit-side counterpart of the receive FIFO in the existing UART. It sits between the J1 I/O write decode and the TX pin, so the CPU can queue bytes with single-cycle writes instead of polling `busy` per byte. It holds the line idle for a guard period after reset so the far end resynchronises before the first frame.

## Interface
- `CLK_DIV`, default 104: clock cycles per bit period (12 MHz / 115200 baud); legal range ≥ 2.
- `DEPTH_LOG2`, default 3: log2 of FIFO depth (8 entries).
- `GUARD_BITS`, default 15: idle-high bit periods after reset before the first frame may start.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr` in 1: write strobe; pushes `tx_data` when not full.
- `tx_data` in 8: byte to queue.
- `tx` out 1: serial output; idle high.
- `full` out 1: FIFO holds 2^DEPTH_LOG2 bytes.
- `empty` out 1: FIFO holds no bytes. The shifter may still be active.
- `level` out DEPTH_LOG2+1: number of bytes queued, excluding the byte in the shifter.
- `busy` out 1: guard active, frame in progress, or FIFO non-empty.
- `overflow` out 1: sticky; set when `wr` arrives while `full`. Cleared only by reset.

## Operation
- FIFO uses read and write pointers of DEPTH_LOG2+1 bits.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `level` = wptr − rptr, computed modulo 2^(DEPTH_LOG2+1).
- A write while `full` is dropped and sets `overflow`. `full` is evaluated before any same-cycle pop, so a write in the cycle a pop frees a slot is still dropped.
- A simultaneous write and pop with the FIFO non-full: both occur and `level` is unchanged.
- FSM states: GUARD, IDLE, SHIFT.
  - GUARD: `tx`=1. Counts GUARD_BITS×CLK_DIV cycles, then goes to IDLE. Writes are accepted during GUARD.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head, load the 10-bit shift register {1, byte, 0}, clear the bit counter and divider, and go to SHIFT.
  - SHIFT: `tx` = shift register bit 0. When the divider reaches CLK_DIV−1, shift right filling with 1 and increment the bit counter.
  - After the 10th bit (stop bit) completes: if the FIFO is non-empty, pop and load directly, with no idle gap. Otherwise go to IDLE.
- Data is sent LSB first, one start bit (0), one stop bit (1), no parity.
- The divider is $clog2(CLK_DIV) bits wide and wraps to 0 on each bit boundary.
- Reset mid-frame: `tx` goes high immediately, the FIFO empties, `overflow` clears, and the FSM restarts in GUARD. The partial frame is abandoned.

## Timing
- Reset values:
  - `tx`=1, `full`=0, `empty`=1, `level`=0, `overflow`=0.
  - `busy`=1, because the FSM is in GUARD.
- A write at edge n is visible at n+1: `empty`=0, `level` incremented.
- In IDLE, a write at edge n pops at edge n+1. The `tx` start bit begins at n+2 (the `tx` output is registered).
- Each bit lasts exactly CLK_DIV cycles; a frame lasts 10×CLK_DIV cycles.
- Back-to-back queued bytes: the next start bit immediately follows the stop-bit period, with zero extra cycles.
- `busy` falls in the cycle after the final stop bit completes with the FIFO empty.
- Outputs `full`, `empty`, `level`, `overflow` and `busy` are registered or derived from registered state only. There is no combinational path from `wr`.

## Structure
- Shared package `uart_pkg`:
  - default CLK_DIV constant;
  - FRAME_BITS=10;
  - FSM state enum {GUARD, IDLE, SHIFT};
  - the same constants reused by the RX side.
- Sub-module `uart_byte_fifo`: parameterised synchronous FIFO with push, pop, full, empty and level. It is reusable for a later RX rewrite.
- Top level: FSM, divider, bit counter and shift register.

## Test plan
- Use CLK_DIV=4 and GUARD_BITS=2 for all scenarios.
- Reset → `tx`=1 and `busy`=1 for 8 cycles. The FSM reaches IDLE with no start bit, and `busy` then falls.
- After the guard, write 0x55 → `tx` reads 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles, and the start bit begins 2 cycles after `wr`.
- Write 0xA5, 0x3C, 0xFF on consecutive cycles → 30 contiguous bit periods with no idle gap, and `level` sequences 1,2,3 then drains.
- Hold IDLE blocked by GUARD and write 9 bytes → `full`=1 after 8; the 9th write is dropped and `overflow`=1. All 8 bytes are transmitted in order and `overflow` stays 1.
- Assert `reset` during bit 4 of 0x81 → `tx`=1 in the same cycle, `level`=0 and `overflow`=0. The frame is not resumed.
- With the FIFO full, write in the same cycle the FSM pops → `level` goes 8→7, and the write is dropped with `overflow`=1.
